// File: rtl/cnn_ups_nn_2x_if.sv
// Pixel stream bundle for the 2x nearest-neighbour upsampler: input handshake plus output stream.
// Latency: none, wires only.
// Backpressure: ready_in is driven by the slave; the output stream carries no ready.
//
// Signals:
//   valid_in   master->slave  pxl_in valid
//   pxl_in     master->slave  input pixel, raster order within a plane, planes in sequence
//   ready_in   slave->master  slave accepts pxl_in this cycle
//   pxl_out    slave->master  upsampled pixel
//   valid_out  slave->master  pxl_out valid
//   frame_last slave->master  pulse with the last output pixel of each channel plane
//   done       slave->master  pulse with the last output pixel of the last channel
interface cnn_ups_nn_2x_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] pxl_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] pxl_out;
    logic                  valid_out;
    logic                  frame_last;
    logic                  done;

    modport master (
        output valid_in,
        output pxl_in,
        input  ready_in,
        input  pxl_out,
        input  valid_out,
        input  frame_last,
        input  done
    );

    modport slave (
        input  valid_in,
        input  pxl_in,
        output ready_in,
        output pxl_out,
        output valid_out,
        output frame_last,
        output done
    );
endinterface

// File: rtl/cnn_ups_nn_2x.sv
// Streaming 2x nearest-neighbour upsampler: each pixel is emitted twice per row, each row twice.
// Latency: first output 2 edges after a row's last pixel is accepted (3 with UPS_OUT_REG_EN).
// Backpressure: ready_in drops only while both line buffers hold unread rows; no output backpressure.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    cnn_ups_nn_2x_if.slave (valid_in/pxl_in/ready_in in, pxl_out/valid_out/frame_last/done out)
// Configuration macro: UPS_OUT_REG_EN adds one register stage on all outputs (latency +1).
module cnn_ups_nn_2x #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CHANNEL_NUM  = 512,
    parameter int ADDR_WIDTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    cnn_ups_nn_2x_if.slave bus
);
    localparam int ROW_W = $clog2(2 * IMAGE_HEIGHT);
    localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(2 * IMAGE_HEIGHT - 1);
    localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(CHANNEL_NUM - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    // Ping-pong line buffers; storage is never reset, the full flags gate its use.
    logic [DATA_WIDTH-1:0] lbuf_q [2][IMAGE_WIDTH];
    logic [1:0]            full_q, full_d;

    // Writer
    logic                  wr_sel_q, wr_sel_d;
    logic [ADDR_WIDTH-1:0] wr_col_q, wr_col_d;
    logic                  accept;
    logic                  wr_last;

    // Reader
    logic [0:0]            state_q, state_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  dup_q, dup_d;
    logic [ADDR_WIDTH-1:0] rcol_q, rcol_d;
    logic                  rep_q, rep_d;
    logic [ROW_W-1:0]      orow_q, orow_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  rd_en;
    logic                  row_end;
    logic                  clr_full;

    // Read register
    logic [DATA_WIDTH-1:0] rd_pxl_q;
    logic                  rd_vld_q;
    logic                  rd_fl_q, rd_fl_d;
    logic                  rd_done_q, rd_done_d;

    assign bus.ready_in = ~full_q[wr_sel_q];
    assign accept       = bus.valid_in & ~full_q[wr_sel_q];
    assign wr_last      = (wr_col_q == COL_LAST);

    always_comb begin
        wr_col_d = wr_col_q;
        wr_sel_d = wr_sel_q;
        if (accept) begin
            wr_col_d = wr_last ? '0 : wr_col_q + 1'b1;
            wr_sel_d = wr_sel_q ^ wr_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            lbuf_q[wr_sel_q][wr_col_q] <= bus.pxl_in;
        end
    end

    // Reader: dup is innermost, then rcol, then rep; one buffer read per EMIT cycle.
    assign row_end = dup_q && (rcol_q == COL_LAST);

    always_comb begin
        state_d   = state_q;
        rd_sel_d  = rd_sel_q;
        dup_d     = dup_q;
        rcol_d    = rcol_q;
        rep_d     = rep_q;
        orow_d    = orow_q;
        ch_d      = ch_q;
        rd_en     = 1'b0;
        clr_full  = 1'b0;
        rd_fl_d   = 1'b0;
        rd_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_sel_q]) begin
                    state_d = EMIT;
                    dup_d   = 1'b0;
                    rcol_d  = '0;
                    rep_d   = 1'b0;
                end
            end
            default: begin
                rd_en = 1'b1;
                dup_d = ~dup_q;
                if (dup_q) begin
                    rcol_d = row_end ? '0 : rcol_q + 1'b1;
                end
                if (row_end) begin
                    rep_d = ~rep_q;
                    if (orow_q == ROW_LAST) begin
                        orow_d  = '0;
                        rd_fl_d = 1'b1;
                        if (ch_q == CH_LAST) begin
                            ch_d      = '0;
                            rd_done_d = 1'b1;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        orow_d = orow_q + 1'b1;
                    end
                    if (rep_q) begin
                        // Row fully replayed: release the buffer and chain straight
                        // into the other one if it was already waiting.
                        clr_full = 1'b1;
                        rd_sel_d = ~rd_sel_q;
                        state_d  = full_q[~rd_sel_q] ? EMIT : IDLE;
                    end
                end
            end
        endcase
    end

    // Writer set and reader clear always hit different buffers.
    always_comb begin
        full_d = full_q;
        if (accept && wr_last) begin
            full_d[wr_sel_q] = 1'b1;
        end
        if (clr_full) begin
            full_d[rd_sel_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            wr_sel_q  <= 1'b0;
            wr_col_q  <= '0;
            state_q   <= IDLE;
            rd_sel_q  <= 1'b0;
            dup_q     <= 1'b0;
            rcol_q    <= '0;
            rep_q     <= 1'b0;
            orow_q    <= '0;
            ch_q      <= '0;
            rd_pxl_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_fl_q   <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            wr_col_q  <= wr_col_d;
            state_q   <= state_d;
            rd_sel_q  <= rd_sel_d;
            dup_q     <= dup_d;
            rcol_q    <= rcol_d;
            rep_q     <= rep_d;
            orow_q    <= orow_d;
            ch_q      <= ch_d;
            rd_vld_q  <= rd_en;
            rd_fl_q   <= rd_fl_d;
            rd_done_q <= rd_done_d;
            if (rd_en) begin
                rd_pxl_q <= lbuf_q[rd_sel_q][rcol_q];
            end
        end
    end

`ifdef UPS_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_pxl_q;
    logic                  out_vld_q;
    logic                  out_fl_q;
    logic                  out_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_pxl_q  <= '0;
            out_vld_q  <= 1'b0;
            out_fl_q   <= 1'b0;
            out_done_q <= 1'b0;
        end else begin
            out_pxl_q  <= rd_pxl_q;
            out_vld_q  <= rd_vld_q;
            out_fl_q   <= rd_fl_q;
            out_done_q <= rd_done_q;
        end
    end

    assign bus.pxl_out    = out_pxl_q;
    assign bus.valid_out  = out_vld_q;
    assign bus.frame_last = out_fl_q;
    assign bus.done       = out_done_q;
`else
    assign bus.pxl_out    = rd_pxl_q;
    assign bus.valid_out  = rd_vld_q;
    assign bus.frame_last = rd_fl_q;
    assign bus.done       = rd_done_q;
`endif

endmodule

// File: tb/tb_cnn_ups_nn_2x.sv
// Bench for cnn_ups_nn_2x with W=4, H=2, C=2; expected outputs pushed per completed input row.
// Latency: checked against 2 edges (3 with UPS_OUT_REG_EN) from last-pixel accept.
// Backpressure: stall point and ready recovery checked under continuous valid_in.
module tb_cnn_ups_nn_2x;
    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int C  = 2;
`ifdef UPS_OUT_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic          fl;
        logic          dn;
    } exp_t;

    logic clk;
    logic reset;
    cnn_ups_nn_2x_if #(.DATA_WIDTH(DW)) bus ();

    cnn_ups_nn_2x #(
        .DATA_WIDTH  (DW),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .CHANNEL_NUM (C),
        .ADDR_WIDTH  (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    int   out_cyc_q[$];

    // Reference model state
    logic [DW-1:0] row_buf [W];
    int in_col = 0;
    int in_row = 0;
    int in_ch  = 0;

    // Driver bookkeeping
    int acc_cnt         = 0;
    int last_acc_cyc    = 0;
    int stall_cnt       = 0;
    int first_stall_acc = -1;
    int recov_cyc       = -1;

    // Monitor bookkeeping
    int burst_pos = 0;
    bit first_arm = 1'b0;
    int first_cyc = 0;
    int fl_cnt    = 0;
    int done_cnt  = 0;

    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        row_buf[in_col] = d;
        in_col++;
        if (in_col == W) begin
            for (int rep = 0; rep < 2; rep++) begin
                for (int c = 0; c < W; c++) begin
                    for (int dup = 0; dup < 2; dup++) begin
                        e.d  = row_buf[c];
                        e.fl = (rep == 1) && (c == W - 1) && (dup == 1) && (in_row == H - 1);
                        e.dn = e.fl && (in_ch == C - 1);
                        sb_q.push_back(e);
                    end
                end
            end
            in_col = 0;
            in_row++;
            if (in_row == H) begin
                in_row = 0;
                in_ch  = (in_ch + 1) % C;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            burst_pos = 0;
        end else begin
            if (burst_pos != 0) begin
                n_cmp++;
                if (bus.valid_out !== 1'b1) begin
                    n_err++;
                    $display("FAIL burst_gap: valid_out=%b at burst position %0d, required 1", bus.valid_out, burst_pos);
                    burst_pos = 0;
                end
            end
            if (bus.valid_out === 1'b1) begin
                out_cyc_q.push_back(cyc);
                if (first_arm) begin
                    first_cyc = cyc;
                    first_arm = 1'b0;
                end
                if (bus.frame_last === 1'b1) fl_cnt++;
                if (bus.done === 1'b1) done_cnt++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: pxl_out=%0d with no pending expectation", bus.pxl_out);
                end else begin
                    e = sb_q.pop_front();
                    n_cmp++;
                    if (bus.pxl_out !== e.d) begin
                        n_err++;
                        $display("FAIL pxl_out: got %0d, required %0d", bus.pxl_out, e.d);
                    end
                    if ({bus.frame_last, bus.done} !== {e.fl, e.dn}) begin
                        n_err++;
                        $display("FAIL flags: got frame_last=%b done=%b, required %b %b (data %0d)",
                                 bus.frame_last, bus.done, e.fl, e.dn, e.d);
                    end
                end
                burst_pos = (burst_pos + 1) % (4 * W);
            end else if (bus.frame_last !== 1'b0 || bus.done !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL idle_flags: frame_last=%b done=%b with valid_out=0, required 0 0",
                         bus.frame_last, bus.done);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with valid_in still high.
    task automatic drive_px(input logic [DW-1:0] d);
        int n = 0;
        bus.valid_in = 1'b1;
        bus.pxl_in   = d;
        if (!bus.ready_in) begin
            stall_cnt++;
            if (first_stall_acc < 0) first_stall_acc = acc_cnt;
        end
        while (!bus.ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_in) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: ready_in=0 for %0d cycles, required 1", n);
            return;
        end
        if (n > 0 && recov_cyc < 0) recov_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        acc_cnt++;
        last_acc_cyc = cyc;
        model_accept(d);
    endtask

    task automatic wait_drain();
        int n = 0;
        bus.valid_in = 1'b0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d outputs still pending, required 0", sb_q.size());
        end
    endtask

    // Pulses reset for one edge and checks the post-reset outputs.
    task automatic test_reset();
        bus.valid_in = 1'b0;
        reset = 1'b1;
        sb_q.delete();
        in_col = 0;
        in_row = 0;
        in_ch  = 0;
        @(negedge clk);
        reset = 1'b0;
        n_cmp += 5;
        if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid_out: got %b, required 0", bus.valid_out); end
        if (bus.pxl_out !== '0) begin n_err++; $display("FAIL rst_pxl_out: got %0d, required 0", bus.pxl_out); end
        if (bus.frame_last !== 1'b0) begin n_err++; $display("FAIL rst_frame_last: got %b, required 0", bus.frame_last); end
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, required 0", bus.done); end
        if (bus.ready_in !== 1'b1) begin n_err++; $display("FAIL rst_ready_in: got %b, required 1", bus.ready_in); end
    endtask

    task automatic check_pulses(input string name, input int fl_req, input int dn_req);
        n_cmp++;
        if (fl_cnt !== fl_req || done_cnt !== dn_req) begin
            n_err++;
            $display("FAIL %s_pulses: got frame_last=%0d done=%0d, required %0d %0d",
                     name, fl_cnt, done_cnt, fl_req, dn_req);
        end
    endtask

    task automatic test_basic();
        int acc4;
        fl_cnt = 0;
        done_cnt = 0;
        first_arm = 1'b1;
        for (int i = 1; i <= 4; i++) drive_px(DW'(i));
        acc4 = last_acc_cyc;
        for (int i = 5; i <= 8; i++) drive_px(DW'(i));
        wait_drain();
        n_cmp++;
        if (first_cyc - acc4 !== 2 + EXTRA) begin
            n_err++;
            $display("FAIL first_latency: got %0d edges, required %0d", first_cyc - acc4, 2 + EXTRA);
        end
        check_pulses("basic", 1, 0);
    endtask

    task automatic test_second_plane();
        fl_cnt = 0;
        done_cnt = 0;
        for (int i = 9; i <= 16; i++) drive_px(DW'(i));
        wait_drain();
        check_pulses("plane2", 1, 1);
    endtask

    task automatic test_back_to_back();
        acc_cnt = 0;
        stall_cnt = 0;
        first_stall_acc = -1;
        recov_cyc = -1;
        out_cyc_q.delete();
        for (int i = 0; i < 16; i++) drive_px(DW'(100 + i));
        wait_drain();
        n_cmp++;
        if (first_stall_acc !== 8) begin
            n_err++;
            $display("FAIL stall_point: first stall after %0d accepts, required 8", first_stall_acc);
        end
        n_cmp++;
        if (out_cyc_q.size() < 16 || out_cyc_q[15] !== recov_cyc + EXTRA) begin
            n_err++;
            $display("FAIL ready_recovery: ready_in back at cycle %0d, 16th output at cycle %0d, required offset %0d",
                     recov_cyc, (out_cyc_q.size() >= 16) ? out_cyc_q[15] : -1, EXTRA);
        end
    endtask

    task automatic test_slow();
        stall_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            drive_px(DW'(i));
            bus.valid_in = 1'b0;
            repeat (4) @(negedge clk);
        end
        wait_drain();
        n_cmp++;
        if (stall_cnt !== 0) begin
            n_err++;
            $display("FAIL slow_stall: ready_in low %0d times, required 0", stall_cnt);
        end
    endtask

    task automatic test_reset_recover(input int pre_px, input int pre_wait);
        for (int i = 1; i <= pre_px; i++) drive_px(DW'(50 + i));
        bus.valid_in = 1'b0;
        repeat (pre_wait) @(negedge clk);
        test_reset();
        fl_cnt = 0;
        done_cnt = 0;
        for (int i = 1; i <= 8; i++) drive_px(DW'(i));
        wait_drain();
        check_pulses("after_reset", 1, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.valid_in = 1'b0;
        bus.pxl_in = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_second_plane();
        test_back_to_back();
        test_slow();
        test_reset_recover(3, 0);
        test_reset_recover(6, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
